// File: rtl/pe_input_streamer.sv
// Transmitter for the PE Input rdy/ack channel: walks a tile channel-outer / width-inner,
// reads each word from a synchronous-read buffer and presents it through a 2-entry prefetch FIFO.
module pe_input_streamer #(
  parameter int unsigned DW     = 16,
  parameter int unsigned AW     = 10,
  parameter int unsigned MAXPCH = 12,
  parameter int unsigned MAXTW  = 64,
  localparam int unsigned PCHW  = $clog2(MAXPCH + 1),
  localparam int unsigned TWW   = $clog2(MAXTW + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [AW-1:0]   i_base,
  input  logic [PCHW-1:0] i_pch,
  input  logic [TWW-1:0]  i_tw,
  input  logic            i_stall,
  output logic            o_rd_en,
  output logic [AW-1:0]   o_rd_addr,
  input  logic [DW-1:0]   i_rd_dat,
  output logic            Input_rdy,
  input  logic            Input_ack,
  output logic [DW-1:0]   o_Input_dat,
  output logic            o_Input_last,
  output logic            o_busy,
  output logic            o_done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;
  logic            done_q, done_d;

  logic [PCHW-1:0] pch_q, ch_q;
  logic [TWW-1:0]  tw_q, w_q;
  // Running address equals base + ch*tw + w, wrapping naturally at AW bits.
  logic [AW-1:0]   addr_q;

  logic            inflight_q, inflight_last_q;

  logic [DW-1:0]   fifo_dat_q [2];
  logic [1:0]      fifo_last_q;
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      count_q;

  logic            rdy, pop, rd_en, last_rd, zero_size;
  logic [2:0]      occ;

  assign rdy       = (count_q != 2'd0);
  assign pop       = rdy && Input_ack;
  assign last_rd   = (ch_q == pch_q - PCHW'(1)) && (w_q == tw_q - TWW'(1));
  assign zero_size = (pch_q == '0) || (tw_q == '0);

  // Occupancy after this cycle's push/pop; a new read may only go out if a slot is left for it.
  assign occ   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign rd_en = (state_q == StRun) && !i_stall && (occ < 3'd2);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = ((i_pch == '0) || (i_tw == '0)) ? StDrain : StRun;
        end
      end
      StRun: begin
        if (rd_en && last_rd) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (zero_size || (pop && fifo_last_q[rd_ptr_q])) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= StIdle;
      done_q          <= 1'b0;
      pch_q           <= '0;
      tw_q            <= '0;
      ch_q            <= '0;
      w_q             <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_dat_q[0]   <= '0;
      fifo_dat_q[1]   <= '0;
      fifo_last_q     <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      done_q          <= done_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && last_rd;

      if ((state_q == StIdle) && i_start) begin
        pch_q  <= i_pch;
        tw_q   <= i_tw;
        addr_q <= i_base;
        ch_q   <= '0;
        w_q    <= '0;
      end else if (rd_en) begin
        addr_q <= addr_q + AW'(1);
        if (w_q == tw_q - TWW'(1)) begin
          w_q  <= '0;
          ch_q <= ch_q + PCHW'(1);
        end else begin
          w_q <= w_q + TWW'(1);
        end
      end

      if (inflight_q) begin
        fifo_dat_q[wr_ptr_q]  <= i_rd_dat;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(inflight_q) - 2'(pop);
    end
  end

  assign o_rd_en      = rd_en;
  assign o_rd_addr    = (state_q == StRun) ? addr_q : '0;
  assign Input_rdy    = rdy;
  assign o_Input_dat  = rdy ? fifo_dat_q[rd_ptr_q] : '0;
  assign o_Input_last = rdy && fifo_last_q[rd_ptr_q];
  assign o_busy       = (state_q != StIdle);
  assign o_done       = done_q;

endmodule

// File: tb/tb_pe_input_streamer.sv
// Bench for pe_input_streamer: word-count model of the tile (reads issued, words arrived,
// words transferred) checked every cycle, plus literal timing expectations per directed tile.
module tb_pe_input_streamer;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [9:0]  i_base;
  logic [3:0]  i_pch;
  logic [6:0]  i_tw;
  logic        i_stall;
  logic        o_rd_en;
  logic [9:0]  o_rd_addr;
  logic [15:0] i_rd_dat;
  logic        Input_rdy;
  logic        Input_ack;
  logic [15:0] o_Input_dat;
  logic        o_Input_last;
  logic        o_busy;
  logic        o_done;

  pe_input_streamer dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_base      (i_base),
    .i_pch       (i_pch),
    .i_tw        (i_tw),
    .i_stall     (i_stall),
    .o_rd_en     (o_rd_en),
    .o_rd_addr   (o_rd_addr),
    .i_rd_dat    (i_rd_dat),
    .Input_rdy   (Input_rdy),
    .Input_ack   (Input_ack),
    .o_Input_dat (o_Input_dat),
    .o_Input_last(o_Input_last),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Buffer contents: {salt, address}; salt 0 gives buffer[a] = a.
  int mem_salt = 0;
  bit pend = 0;
  int pend_addr = 0;

  // Tile model in terms of word counts.
  bit m_active = 0;
  bit m_zero = 0;
  bit m_done = 0;
  int m_base = 0, m_n = 0, m_salt = 0;
  int m_iss = 0;   // reads issued before this cycle
  int m_prev = 0;  // reads issued at least two cycles ago (data already in the FIFO)
  int m_xfer = 0;  // words transferred
  bit rst_chk = 0;

  // Observed per-tile statistics, cycle 0 = start cycle.
  int s_cyc = 0, s_first_rdy = -1, s_last_xfer = -1, s_done_cyc = -1;
  int s_reads = 0, s_xfer = 0, s_done_cnt = 0, s_prev_addr = -1;
  bit s_wrap = 0;
  int bp_reads = -1;

  function automatic int memv(input int salt, input int a);
    return ((salt % 64) << 10) | (a & 1023);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic cycle(input bit st, input int b, input int p, input int t,
                       input bit sl, input bit ak, input bit rs);
    bit a, rdy_e, pop_e, run_e, rden_e, nd;
    i_start   = st;
    i_base    = b[9:0];
    i_pch     = p[3:0];
    i_tw      = t[6:0];
    i_stall   = sl;
    Input_ack = ak;
    i_rst     = rs;
    i_rd_dat  = pend ? 16'(memv(mem_salt, pend_addr)) : 16'($urandom);
    @(negedge i_clk);
    pend      = o_rd_en;
    pend_addr = int'(o_rd_addr);
    if (rs) begin
      m_active = 0; m_done = 0; m_iss = 0; m_prev = 0; m_xfer = 0;
      rst_chk  = 1;
    end else begin
      if (rst_chk) begin
        check("rst_rd_en", o_rd_en, 0);
        check("rst_rd_addr", o_rd_addr, 0);
        check("rst_rdy", Input_rdy, 0);
        check("rst_dat", o_Input_dat, 0);
        check("rst_last", o_Input_last, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        rst_chk = 0;
      end
      a      = m_active;
      rdy_e  = m_active && (m_prev > m_xfer);
      pop_e  = rdy_e && ak;
      run_e  = m_active && !m_zero && (m_iss < m_n);
      rden_e = run_e && !sl && ((m_iss - m_xfer - int'(pop_e)) < 2);
      check("rd_en", o_rd_en, rden_e);
      check("Input_rdy", Input_rdy, rdy_e);
      check("busy", o_busy, m_active);
      check("done", o_done, m_done);
      if (rden_e && o_rd_en) check("rd_addr", o_rd_addr, (m_base + m_iss) % 1024);
      if (rdy_e && Input_rdy) begin
        check("Input_dat", o_Input_dat, memv(m_salt, m_base + m_xfer));
        check("Input_last", o_Input_last, int'(m_xfer == m_n - 1));
      end
      // Observed statistics.
      if (Input_rdy && s_first_rdy < 0) s_first_rdy = s_cyc;
      if (o_rd_en) begin
        s_reads++;
        if (s_prev_addr == 1023 && o_rd_addr == 10'd0) s_wrap = 1;
        s_prev_addr = int'(o_rd_addr);
      end
      if (Input_rdy && ak) begin
        s_xfer++;
        s_last_xfer = s_cyc;
      end
      if (o_done) begin
        s_done_cnt++;
        s_done_cyc = s_cyc;
      end
      s_cyc++;
      // Advance the model.
      nd = 0;
      m_prev = m_iss;
      if (rden_e) m_iss++;
      if (pop_e) begin
        m_xfer++;
        if (m_xfer == m_n) begin
          m_active = 0;
          nd = 1;
        end
      end else if (m_active && m_zero) begin
        m_active = 0;
        nd = 1;
      end
      if (st && !a) begin
        m_active = 1; m_base = b; m_n = p * t; m_zero = (m_n == 0);
        m_iss = 0; m_prev = 0; m_xfer = 0; m_salt = mem_salt;
        s_cyc = 1; s_first_rdy = -1; s_last_xfer = -1; s_done_cyc = -1;
        s_reads = 0; s_xfer = 0; s_done_cnt = 0; s_prev_addr = -1; s_wrap = 0;
      end
      m_done = nd;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 1, 0);
  endtask

  // mode 0: ack=1; 1: ack low cycles 3..8; 2: stall cycles 2..5; 3: random; 4: stray start at cycle 4
  task automatic run_tile(input int b, input int p, input int t, input int mode);
    int c;
    bit ak, sl, st;
    cycle(1, b, p, t, 0, 1, 0);
    c = 1;
    for (int k = 0; k < 20000 && m_active; k++) begin
      ak = 1; sl = 0; st = 0;
      case (mode)
        1: ak = !(c >= 3 && c <= 8);
        2: sl = (c >= 2 && c <= 5);
        3: begin
          ak = ($urandom_range(0, 99) < 75);
          sl = ($urandom_range(0, 99) < 15);
        end
        4: st = (c == 4);
        default: ;
      endcase
      if (st) cycle(1, 10'h200, 3, 2, sl, ak, 0);
      else cycle(0, 0, 0, 0, sl, ak, 0);
      if (mode == 1 && c == 8) bp_reads = s_reads;
      c++;
    end
    check("tile_timeout", m_active, 0);
  endtask

  initial begin
    i_rst = 1; i_start = 0; i_base = 0; i_pch = 0; i_tw = 0;
    i_stall = 0; Input_ack = 0; i_rd_dat = 0;
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle();

    // Nominal tile.
    mem_salt = 0;
    run_tile(10'h10, 2, 3, 0);
    idle();
    check("nom_first_rdy", s_first_rdy, 3);
    check("nom_last_xfer", s_last_xfer, 8);
    check("nom_done_cyc", s_done_cyc, 9);
    check("nom_reads", s_reads, 6);
    check("nom_xfers", s_xfer, 6);
    check("nom_done_cnt", s_done_cnt, 1);

    // Backpressure.
    run_tile(10'h10, 2, 3, 1);
    idle();
    check("bp_reads_by_c8", bp_reads, 2);
    check("bp_xfers", s_xfer, 6);
    check("bp_done_cyc", s_done_cyc, 15);

    // Stall.
    run_tile(10'h80, 1, 4, 2);
    idle();
    check("stall_reads", s_reads, 4);
    check("stall_xfers", s_xfer, 4);
    check("stall_done_cyc", s_done_cyc, 11);

    // Largest tile, address wraps past 0x3FF.
    mem_salt = 5;
    run_tile(10'h3F0, 12, 64, 3);
    idle();
    check("big_xfers", s_xfer, 768);
    check("big_reads", s_reads, 768);
    check("big_wrap", s_wrap, 1);
    check("big_done_cnt", s_done_cnt, 1);

    // Zero-size tile.
    run_tile(10'h20, 0, 5, 0);
    idle();
    check("zero_reads", s_reads, 0);
    check("zero_rdy", s_first_rdy, -1);
    check("zero_done_cyc", s_done_cyc, 2);
    check("zero_done_cnt", s_done_cnt, 1);

    // Start during RUN is ignored.
    mem_salt = 7;
    run_tile(10'h100, 2, 3, 4);
    idle();
    check("ign_xfers", s_xfer, 6);
    check("ign_done_cyc", s_done_cyc, 9);

    // Reset with two words buffered, then a fresh tile with different buffer contents.
    mem_salt = 1;
    cycle(1, 10'h40, 2, 3, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    mem_salt = 2;
    idle();
    run_tile(10'h40, 2, 3, 0);
    idle();
    check("rst_new_xfers", s_xfer, 6);
    check("rst_new_done_cyc", s_done_cyc, 9);

    // Random back-to-back tiles; each start lands in the previous tile's done cycle.
    for (int i = 0; i < 8; i++) begin
      mem_salt = int'($urandom_range(3, 63));
      run_tile(int'($urandom_range(0, 1023)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 8)), 3);
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
